lx_mem_arbiter: RTL
===================

LX_MEM_ARBITER -- requirements
Module: lx_mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, request address width in bits.
REQ-002 Parameter BLK_W, default 128, cache-line data width in bits.
REQ-003 Parameter STARVE_LIM, default 4, consecutive data-side grants allowed while the instruction side waits.
REQ-004 Ports SHALL be:
- clk_i  in  1  single clock; all state on rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- ic_req_valid_i  in  1  instruction-cache line request.
- ic_req_addr_i  in  ADDR_W  instruction request address.
- ic_req_ready_o  out  1  instruction request accepted this cycle.
- ic_res_valid_o  out  1  instruction response strobe.
- ic_res_data_o  out  BLK_W  instruction response line.
- dc_req_valid_i  in  1  data-cache request.
- dc_req_addr_i  in  ADDR_W  data request address.
- dc_req_rw_i  in  1  1 = write-back, 0 = fill.
- dc_req_data_i  in  BLK_W  write-back line.
- dc_req_ready_o  out  1  data request accepted this cycle.
- dc_res_valid_o  out  1  data response strobe.
- dc_res_data_o  out  BLK_W  data response line.
- mem_req_valid_o  out  1  downstream request valid.
- mem_req_ready_i  in  1  downstream accepts request.
- mem_req_addr_o  out  ADDR_W  downstream address.
- mem_req_rw_o  out  1  downstream write flag (0 for instruction side).
- mem_req_data_o  out  BLK_W  downstream write line.
- mem_req_id_o  out  1  owner tag: 0 = instruction, 1 = data.
- mem_res_valid_i  in  1  downstream response strobe; returned for reads and writes.
- mem_res_data_i  in  BLK_W  downstream response line.

Function
REQ-005 FSM states: IDLE, ISSUE, WAIT_RES; exactly one transaction outstanding.
REQ-006 IDLE: when any req_valid is high, assert the winner's req_ready for one cycle, capture addr/rw/data/owner into holding registers, and enter ISSUE next cycle.
REQ-007 ISSUE: drive mem_req_valid_o=1 with held fields; hold them stable until mem_req_ready_i=1, then enter WAIT_RES.
REQ-008 WAIT_RES: on mem_res_valid_i=1, pulse the owner's res_valid for that same cycle with data = mem_res_data_i and return to IDLE; the other side's res_valid stays 0.
REQ-009 mem_res_valid_i outside WAIT_RES is ignored; req_ready is never asserted outside IDLE.
REQ-010 Earliest re-grant is the cycle after a response; minimum transaction occupancy is 3 cycles.
REQ-011 Default arbitration: data side wins ties, except that once the data side has been granted STARVE_LIM consecutive times while ic_req_valid_i was high, the next tie goes to the instruction side.
REQ-012 Starvation counter increments on a data grant made while ic_req_valid_i=1, clears on any instruction grant or when ic_req_valid_i=0 at a data grant, and saturates at STARVE_LIM.
REQ-013 A lone valid requester is always granted, regardless of the arbitration policy.
REQ-014 Requesters hold valid and fields until ready; the arbiter samples fields only at grant.

Reset
REQ-015 rst_i asserted: FSM→IDLE, holding registers, owner, starvation counter and last-grant pointer cleared, all outputs 0, including mid-transaction; the in-flight response is dropped.
REQ-016 Outputs SHALL be 0 throughout reset and in the first cycle after deassertion unless a request is pending.

Configuration
REQ-017 Macro LX_ARB_RR_EN defined: ties alternate round-robin via a last-grant pointer that resets to the instruction side, so data wins the first tie; starvation counter and STARVE_LIM are unused.
REQ-018 Macro LX_ARB_RR_EN undefined: fixed data priority with starvation guard per REQ-011/012.

Verification
REQ-019 Lone instruction read at 0x100, mem_req_ready_i=1 immediately, response 2 cycles later → ic_req_ready_o pulse at T0, mem_req_valid_o at T1 with id=0, ic_res_valid_o with data at T3, dc_res_valid_o stays 0.
REQ-020 Both valid in IDLE, default build → data granted first; instruction granted in the IDLE cycle after the data response.
REQ-021 Data valid continuously with instruction waiting, STARVE_LIM=4 → 4 data grants, then 1 instruction grant, then data again.
REQ-022 mem_req_ready_i held 0 for 5 cycles with write 0xDEADBEEF at 0x2000 → addr, rw=1 and data stable every cycle until acceptance.
REQ-023 rst_i asserted in WAIT_RES, then mem_res_valid_i pulses → no res_valid on either side; FSM in IDLE.
REQ-024 LX_ARB_RR_EN build, both sides valid continuously → grants alternate D, I, D, I.

Source files
------------

// File: rtl/lx_mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : lx_mem_arbiter
//  Purpose  : Two-client (instruction / data cache) arbiter in front of a
//             single-outstanding downstream memory port. Data side wins ties
//             with a starvation guard for the instruction side; defining
//             LX_ARB_RR_EN switches ties to round-robin alternation.
//  Revision : 1.0 - initial release
// ============================================================================
module lx_mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int BLK_W      = 128,
    parameter int STARVE_LIM = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    // instruction cache client
    input  logic              ic_req_valid_i,
    input  logic [ADDR_W-1:0] ic_req_addr_i,
    output logic              ic_req_ready_o,
    output logic              ic_res_valid_o,
    output logic [BLK_W-1:0]  ic_res_data_o,
    // data cache client
    input  logic              dc_req_valid_i,
    input  logic [ADDR_W-1:0] dc_req_addr_i,
    input  logic              dc_req_rw_i,
    input  logic [BLK_W-1:0]  dc_req_data_i,
    output logic              dc_req_ready_o,
    output logic              dc_res_valid_o,
    output logic [BLK_W-1:0]  dc_res_data_o,
    // downstream memory
    output logic              mem_req_valid_o,
    input  logic              mem_req_ready_i,
    output logic [ADDR_W-1:0] mem_req_addr_o,
    output logic              mem_req_rw_o,
    output logic [BLK_W-1:0]  mem_req_data_o,
    output logic              mem_req_id_o,
    input  logic              mem_res_valid_i,
    input  logic [BLK_W-1:0]  mem_res_data_i
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_ISSUE    = 2'd1,
        S_WAIT_RES = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  addr_q,  addr_d;
    logic               rw_q,    rw_d;
    logic [BLK_W-1:0]   data_q,  data_d;
    logic               owner_q, owner_d;   // 0 = instruction, 1 = data

    // High when a tie in IDLE must go to the instruction side.
    logic               w_ic_prio;
    logic               w_grant_dc;

`ifdef LX_ARB_RR_EN
    // Remembers whether the most recent grant went to the data side.
    logic               last_dc_q, last_dc_d;
    assign w_ic_prio = last_dc_q;
`else
    localparam int C_CNT_W = (STARVE_LIM < 1) ? 1 : $clog2(STARVE_LIM + 1);
    localparam logic [C_CNT_W-1:0] C_LIM = C_CNT_W'(STARVE_LIM);
    // Consecutive data grants taken while the instruction side was waiting.
    logic [C_CNT_W-1:0] starve_q, starve_d;
    assign w_ic_prio = (starve_q >= C_LIM);
`endif

    // Next-state, grant decision and all output decoding.
    always_comb begin
        state_d         = state_q;
        addr_d          = addr_q;
        rw_d            = rw_q;
        data_d          = data_q;
        owner_d         = owner_q;
`ifdef LX_ARB_RR_EN
        last_dc_d       = last_dc_q;
`else
        starve_d        = starve_q;
`endif
        w_grant_dc      = 1'b0;
        ic_req_ready_o  = 1'b0;
        dc_req_ready_o  = 1'b0;
        ic_res_valid_o  = 1'b0;
        dc_res_valid_o  = 1'b0;
        ic_res_data_o   = '0;
        dc_res_data_o   = '0;
        mem_req_valid_o = 1'b0;
        mem_req_addr_o  = '0;
        mem_req_rw_o    = 1'b0;
        mem_req_data_o  = '0;
        mem_req_id_o    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (ic_req_valid_i || dc_req_valid_i) begin
                    // A lone requester always wins; a tie follows the policy.
                    w_grant_dc = dc_req_valid_i && (!ic_req_valid_i || !w_ic_prio);
                    if (w_grant_dc) begin
                        dc_req_ready_o = 1'b1;
                        addr_d         = dc_req_addr_i;
                        rw_d           = dc_req_rw_i;
                        data_d         = dc_req_data_i;
                        owner_d        = 1'b1;
                    end else begin
                        ic_req_ready_o = 1'b1;
                        addr_d         = ic_req_addr_i;
                        rw_d           = 1'b0;
                        data_d         = '0;
                        owner_d        = 1'b0;
                    end
`ifdef LX_ARB_RR_EN
                    last_dc_d = w_grant_dc;
`else
                    if (w_grant_dc && ic_req_valid_i) begin
                        if (starve_q != C_LIM) begin
                            starve_d = starve_q + C_CNT_W'(1);
                        end
                    end else begin
                        starve_d = '0;
                    end
`endif
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                mem_req_valid_o = 1'b1;
                mem_req_addr_o  = addr_q;
                mem_req_rw_o    = rw_q;
                mem_req_data_o  = data_q;
                mem_req_id_o    = owner_q;
                if (mem_req_ready_i) begin
                    state_d = S_WAIT_RES;
                end
            end
            S_WAIT_RES: begin
                if (mem_res_valid_i) begin
                    if (owner_q) begin
                        dc_res_valid_o = 1'b1;
                        dc_res_data_o  = mem_res_data_i;
                    end else begin
                        ic_res_valid_o = 1'b1;
                        ic_res_data_o  = mem_res_data_i;
                    end
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Grants are combinational from the request inputs, so keep them
        // quiet while reset is held.
        if (rst_i) begin
            ic_req_ready_o = 1'b0;
            dc_req_ready_o = 1'b0;
        end
    end

    // State and holding registers; reset drops any in-flight transaction.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            rw_q      <= 1'b0;
            data_q    <= '0;
            owner_q   <= 1'b0;
`ifdef LX_ARB_RR_EN
            last_dc_q <= 1'b0;
`else
            starve_q  <= '0;
`endif
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            rw_q      <= rw_d;
            data_q    <= data_d;
            owner_q   <= owner_d;
`ifdef LX_ARB_RR_EN
            last_dc_q <= last_dc_d;
`else
            starve_q  <= starve_d;
`endif
        end
    end

endmodule
`default_nettype wire
